// File: rtl/tcam_pkg.sv
// tcam_pkg: shared sizes, FSM state encoding and rule record for the TCAM rule writer
package tcam_pkg;
  localparam int NUM_ENTRIES  = 64;
  localparam int KEY_W        = 28;
  localparam int SLICE_W      = 7;
  localparam int NUM_BLOCKS   = 4;
  localparam int ROWS         = 128;
  localparam int INIT_WRITES  = NUM_BLOCKS * ROWS * 2;
  localparam int WRITE_WRITES = NUM_BLOCKS * ROWS;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_WRITE,
    S_DONE
  } state_e;

  typedef struct packed {
    logic             valid;
    logic [KEY_W-1:0] value;
    logic [KEY_W-1:0] mask;
  } rule_t;
endpackage

// File: rtl/tcam_lane_encoder.sv
// tcam_lane_encoder: one write-lane byte, bit k set when rule k matches the given block row
module tcam_lane_encoder
  import tcam_pkg::*;
(
  input  rule_t [7:0] rules_i,
  input  logic  [1:0] block_i,
  input  logic  [6:0] row_i,
  output logic  [7:0] lane_o
);
  for (genvar k = 0; k < 8; k++) begin : g_ent
    logic [SLICE_W-1:0] vs, ms;
    assign vs = SLICE_W'(rules_i[k].value >> (SLICE_W * block_i));
    assign ms = SLICE_W'(rules_i[k].mask >> (SLICE_W * block_i));
    assign lane_o[k] = rules_i[k].valid && (((vs ^ row_i) & ~ms) == '0);
  end
endmodule

// File: rtl/tcam_rule_writer.sv
// tcam_rule_writer: keeps a 64-entry rule table and rewrites the TCAM column of each changed entry
module tcam_rule_writer
  import tcam_pkg::*;
(
  input  logic             in_clk,
  input  logic             in_rstb,
  input  logic             in_req_valid,
  output logic             out_req_ready,
  input  logic             in_req_op,
  input  logic [5:0]       in_req_idx,
  input  logic [KEY_W-1:0] in_req_value,
  input  logic [KEY_W-1:0] in_req_mask,
  output logic             out_busy,
  output logic             out_done,
  output logic             out_csb,
  output logic             out_web,
  output logic [3:0]       out_wmask,
  output logic [27:0]      out_addr,
  output logic [31:0]      out_wdata
);
  state_e       state_q, state_d;
  logic [9:0]   cnt_q, cnt_d;
  logic [5:0]   idx_q;
  rule_t        table_q [NUM_ENTRIES];
  logic         ready_q, ready_d;
  logic         done_q, done_d;
  logic         csb_q, csb_d;
  logic         web_q;
  logic [3:0]   wmask_q, wmask_d;
  logic [27:0]  addr_q, addr_d;
  logic [31:0]  wdata_q, wdata_d;
  logic         hs;
  logic         in_init, in_write;
  rule_t [7:0]  lane_rules;
  logic [7:0]   lane;

  assign hs       = in_req_valid & ready_q;
  assign in_init  = state_q == S_INIT;
  assign in_write = state_q == S_WRITE;

  for (genvar k = 0; k < 8; k++) begin : g_sel
    assign lane_rules[k] = table_q[{idx_q[5:3], 3'(k)}];
  end

  tcam_lane_encoder u_enc (
    .rules_i (lane_rules),
    .block_i (cnt_q[8:7]),
    .row_i   (cnt_q[6:0]),
    .lane_o  (lane)
  );

  // next state and write counter; the counter walks block/row(/half) in address order
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 10'd1;
    unique case (state_q)
      S_INIT:  if (cnt_q == 10'(INIT_WRITES - 1)) state_d = S_IDLE;
      S_IDLE: begin
        cnt_d = '0;
        if (hs) state_d = S_WRITE;
      end
      S_WRITE: if (cnt_q == 10'(WRITE_WRITES - 1)) begin
        state_d = S_DONE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // TCAM port values for the next cycle; outputs trail the state by one cycle
  always_comb begin
    csb_d   = !(in_init || in_write);
    wmask_d = in_init ? 4'hF : in_write ? 4'b1 << idx_q[4:3] : '0;
    addr_d  = in_init ? {18'b0, cnt_q} : in_write ? {18'b0, cnt_q[8:0], idx_q[5]} : '0;
    wdata_d = in_write ? {24'b0, lane} << {idx_q[4:3], 3'b000} : '0;
    ready_d = state_q == S_IDLE && state_d == S_IDLE;
    done_d  = state_q == S_DONE;
  end

  // FSM, counter and registered outputs
  always_ff @(posedge in_clk or negedge in_rstb) begin
    if (!in_rstb) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      idx_q   <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      wmask_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (hs) idx_q <= in_req_idx;
      ready_q <= ready_d;
      done_q  <= done_d;
      csb_q   <= csb_d;
      web_q   <= csb_d;
      wmask_q <= wmask_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // rule table updates on the handshake edge; invalidate keeps value and mask
  always_ff @(posedge in_clk or negedge in_rstb) begin
    if (!in_rstb) begin
      for (int i = 0; i < NUM_ENTRIES; i++) table_q[i] <= '0;
    end else if (hs) begin
      table_q[in_req_idx].valid <= in_req_op;
      if (in_req_op) begin
        table_q[in_req_idx].value <= in_req_value;
        table_q[in_req_idx].mask  <= in_req_mask;
      end
    end
  end

  assign out_req_ready = ready_q;
  assign out_busy      = ~ready_q;
  assign out_done      = done_q;
  assign out_csb       = csb_q;
  assign out_web       = web_q;
  assign out_wmask     = wmask_q;
  assign out_addr      = addr_q;
  assign out_wdata     = wdata_q;
endmodule

// File: tb/tb_tcam_rule_writer.sv
// tb_tcam_rule_writer: directed checks of init sweep, rule writes, backpressure and mid-write reset
module tb_tcam_rule_writer;
  logic        in_clk, in_rstb, in_req_valid, in_req_op;
  logic [5:0]  in_req_idx;
  logic [27:0] in_req_value, in_req_mask;
  logic        out_req_ready, out_busy, out_done, out_csb, out_web;
  logic [3:0]  out_wmask;
  logic [27:0] out_addr;
  logic [31:0] out_wdata;
  logic [31:0] wd [512];
  int          errs = 0;
  int          checks = 0;
  int          hs_cnt = 0;

  tcam_rule_writer dut (
    .in_clk        (in_clk),
    .in_rstb       (in_rstb),
    .in_req_valid  (in_req_valid),
    .out_req_ready (out_req_ready),
    .in_req_op     (in_req_op),
    .in_req_idx    (in_req_idx),
    .in_req_value  (in_req_value),
    .in_req_mask   (in_req_mask),
    .out_busy      (out_busy),
    .out_done      (out_done),
    .out_csb       (out_csb),
    .out_web       (out_web),
    .out_wmask     (out_wmask),
    .out_addr      (out_addr),
    .out_wdata     (out_wdata)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  always @(posedge in_clk) if (in_req_valid && out_req_ready) hs_cnt <= hs_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge in_clk);
    #1;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_csb"}, 32'(out_csb), 1);
    chk({tag, "_web"}, 32'(out_web), 1);
    chk({tag, "_wmask"}, 32'(out_wmask), 0);
    chk({tag, "_addr"}, 32'(out_addr), 0);
    chk({tag, "_wdata"}, out_wdata, 0);
    chk({tag, "_ready"}, 32'(out_req_ready), 0);
    chk({tag, "_busy"}, 32'(out_busy), 1);
    chk({tag, "_done"}, 32'(out_done), 0);
  endtask

  task automatic init_seq();
    int bad = 0;
    for (int k = 0; k < 1024; k++) begin
      step();
      if (out_csb !== 1'b0 || out_web !== 1'b0 || out_wmask !== 4'hF || out_wdata !== 32'h0 ||
          out_addr !== 28'(k) || out_req_ready !== 1'b0 || out_busy !== 1'b1) bad++;
    end
    chk("init_seq", bad, 0);
    step();
    chk("init_ready", 32'(out_req_ready), 1);
    chk("init_csb_off", 32'(out_csb), 1);
  endtask

  task automatic send(input logic op, input logic [5:0] idx, input logic [27:0] v, input logic [27:0] m);
    int n = 0;
    in_req_op = op;
    in_req_idx = idx;
    in_req_value = v;
    in_req_mask = m;
    in_req_valid = 1'b1;
    while (out_req_ready !== 1'b1 && n < 2000) begin
      step();
      n++;
    end
    chk("send_wait", 32'(n < 2000), 1);
    step();
    in_req_valid = 1'b0;
  endtask

  task automatic capture(input logic [5:0] idx);
    int bad = 0;
    int dones = 0;
    logic [3:0] em;
    logic [31:0] lm;
    em = 4'b1 << idx[4:3];
    lm = 32'hFF << (8 * idx[4:3]);
    if (out_csb !== 1'b1 || out_req_ready !== 1'b0 || out_busy !== 1'b1) bad++;
    if (out_done === 1'b1) dones++;
    for (int i = 0; i < 512; i++) begin
      step();
      if (out_csb !== 1'b0 || out_web !== 1'b0 || out_wmask !== em || (out_wdata & ~lm) !== 32'h0 ||
          out_addr !== {18'b0, 9'(i), idx[5]} || out_req_ready !== 1'b0 || out_busy !== 1'b1) bad++;
      if (out_done === 1'b1) dones++;
      wd[i] = out_wdata;
    end
    step();
    if (out_csb !== 1'b1 || out_wmask !== 4'h0 || out_addr !== 28'h0 || out_wdata !== 32'h0) bad++;
    chk("done_pulse", 32'(out_done), 1);
    chk("ready_n513", 32'(out_req_ready), 0);
    if (out_done === 1'b1) dones++;
    step();
    chk("done_clear", 32'(out_done), 0);
    chk("ready_n514", 32'(out_req_ready), 1);
    chk("busy_idle", 32'(out_busy), 0);
    chk("done_count", dones, 1);
    chk("wr_seq", bad, 0);
  endtask

  initial begin
    int nz, hs0;
    in_rstb = 1'b0;
    in_req_valid = 1'b0;
    in_req_op = 1'b0;
    in_req_idx = '0;
    in_req_value = '0;
    in_req_mask = '0;
    #12;
    chk_idle_outs("rst");
    @(negedge in_clk);
    in_rstb = 1'b1;
    init_seq();

    send(1'b1, 6'd5, 28'h0000001, 28'h0);
    capture(6'd5);
    chk("i5_b0r1", wd[1], 32'h20);
    chk("i5_b0r0", wd[0], 32'h00);
    chk("i5_b0r2", wd[2], 32'h00);
    chk("i5_b1r0", wd[128], 32'h20);

    send(1'b1, 6'd5, 28'h0000002, 28'h0);
    capture(6'd5);
    chk("re5_b0r2", wd[2], 32'h20);
    chk("re5_b0r1", wd[1], 32'h00);

    send(1'b1, 6'd40, 28'h0, 28'hFFFFFFF);
    capture(6'd40);
    nz = 0;
    for (int i = 0; i < 512; i++) if (wd[i] !== 32'h100) nz++;
    chk("i40_all", nz, 0);

    send(1'b1, 6'd0, 28'h1234567, 28'h0);
    capture(6'd0);
    chk("i0_b0", wd[8'h67], 32'h01);
    send(1'b1, 6'd3, 28'h1234567, 28'h0);
    capture(6'd3);
    chk("i3_b0", wd[8'h67], 32'h09);
    chk("i3_b1", wd[128 + 8'h0A], 32'h09);
    send(1'b0, 6'd0, 28'h0, 28'h0);
    capture(6'd0);
    chk("inv0_b0", wd[8'h67], 32'h08);
    chk("inv0_b1", wd[128 + 8'h0A], 32'h08);

    hs0 = hs_cnt;
    send(1'b0, 6'd3, 28'h0, 28'h0);
    in_req_op = 1'b1;
    in_req_idx = 6'd63;
    in_req_value = 28'h0;
    in_req_mask = 28'hFFFFFFF;
    in_req_valid = 1'b1;
    capture(6'd3);
    chk("inv3_b0", wd[8'h67], 32'h00);
    step();
    in_req_valid = 1'b0;
    capture(6'd63);
    nz = 0;
    for (int i = 0; i < 512; i++) if (wd[i] !== 32'h80000000) nz++;
    chk("held_i63", nz, 0);
    step();
    chk("held_hs", hs_cnt - hs0, 2);

    send(1'b1, 6'd10, 28'h0, 28'h0);
    for (int i = 0; i < 200; i++) step();
    chk("pre_rst_csb", 32'(out_csb), 0);
    in_rstb = 1'b0;
    #1;
    chk_idle_outs("abort");
    step();
    step();
    chk_idle_outs("abort_hold");
    @(negedge in_clk);
    in_rstb = 1'b1;
    init_seq();
    send(1'b0, 6'd4, 28'h0, 28'h0);
    capture(6'd4);
    nz = 0;
    for (int i = 0; i < 512; i++) if (wd[i] !== 32'h0) nz++;
    chk("rst_clr", nz, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/tcam_rule_writer.md
TCAM_RULE_WRITER -- requirements
Module: tcam_rule_writer

Interface
REQ-001 SHALL have port in_clk, input, 1 bit: sole clock, rising edge.
REQ-002 SHALL have port in_rstb, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port in_req_valid, input, 1 bit: rule request valid.
REQ-004 SHALL have port out_req_ready, output, 1 bit: request accepted when valid and ready are both high.
REQ-005 SHALL have port in_req_op, input, 1 bit: 1 = install rule, 0 = invalidate entry.
REQ-006 SHALL have port in_req_idx, input, 6 bits: entry index; lower index wins priority.
REQ-007 SHALL have port in_req_value, input, 28 bits: key value.
REQ-008 SHALL have port in_req_mask, input, 28 bits: 1 = don't-care bit.
REQ-009 SHALL have port out_busy, output, 1 bit: writer owns the TCAM port; search is forbidden.
REQ-010 SHALL have port out_done, output, 1 bit: one-cycle pulse on request completion.
REQ-011 SHALL have TCAM-side outputs out_csb (1), out_web (1), out_wmask (4), out_addr (28) and out_wdata (32), driving the TCAM write port.

Function
REQ-012 The TCAM SHALL be treated as 4 blocks; block b holds key slice [7b+6:7b] as 128 rows x 64 entry bits.
REQ-013 Write address SHALL be: out_addr[9:8] = block, [7:1] = row, [0] = half (0 = entries 31:0, 1 = entries 63:32), [27:10] = 0.
REQ-014 Each write lane SHALL be one byte, covering 8 entries.
REQ-015 Bit k of lane L in half h SHALL describe entry j = 32h + 8L + k.
REQ-016 Entry j in block b, row r SHALL be 1 iff valid_j and ((r XOR value_j slice b) AND NOT mask_j slice b) == 0.
REQ-017 An internal rule table SHALL hold 64 x {valid, value[27:0], mask[27:0]}.
REQ-018 States SHALL be INIT, IDLE, WRITE, DONE.
REQ-019 INIT: SHALL issue 1024 writes in order block, row, half (block outermost) with wmask 4'hF and wdata 0; then go to IDLE.
REQ-020 IDLE: out_req_ready SHALL be 1 and out_busy SHALL be 0.
REQ-021 IDLE, on handshake: the table entry SHALL update in the same edge (install: valid=1, value, mask; invalidate: valid=0, value and mask kept); then go to WRITE.
REQ-022 WRITE: SHALL issue 512 writes, one per cycle, block 0..3 outer and row 0..127 inner.
REQ-023 In WRITE, half SHALL be idx[5], wmask SHALL be onehot(idx[4:3]), and wdata SHALL carry the computed byte in lane idx[4:3] with all other bytes 0.
REQ-024 DONE: out_done SHALL be 1 for exactly one cycle; then go to IDLE.
REQ-025 Latency: handshake at edge N -> writes in cycles N+1..N+512 -> out_done in cycle N+513 -> ready again in N+514.
REQ-026 During every write cycle: out_csb = 0, out_web = 0.
REQ-027 Otherwise: out_csb = 1, out_web = 1, wmask, addr and wdata = 0.
REQ-028 out_busy SHALL be 1 in INIT, WRITE and DONE.
REQ-029 out_req_ready SHALL be 0 outside IDLE; requests held while not ready SHALL be neither lost nor duplicated.
REQ-030 Re-installing an existing index SHALL overwrite it.
REQ-031 Invalidating an already-invalid entry SHALL still run the full WRITE sequence.
REQ-032 All TCAM-side outputs SHALL be registered.

Reset
REQ-033 While in_rstb = 0, outputs SHALL be: out_csb = 1, out_web = 1, out_wmask = 0, out_addr = 0, out_wdata = 0, out_req_ready = 0, out_busy = 1, out_done = 0.
REQ-034 Reset SHALL clear all valid bits and the counters.
REQ-035 The state after reset SHALL be INIT; INIT starts on the first edge after deassertion.
REQ-036 Reset asserted mid-WRITE SHALL abort immediately; no further writes are issued and INIT reruns.

Structure
REQ-037 Package tcam_pkg SHALL hold NUM_ENTRIES = 64, KEY_W = 28, SLICE_W = 7, NUM_BLOCKS = 4, ROWS = 128, the state enum and the rule struct {valid, value, mask}.
REQ-038 One sub-module, tcam_lane_encoder, SHALL be combinational: 8 rules + block + row in -> 8-bit lane byte out.

Verification
REQ-039 Reset release: 1024 writes with wmask F and wdata 0; ready rises in cycle 1025.
REQ-040 Install idx 5, value 0x0000001, mask 0:
- block 0 row 1 gives wdata = 0x20, wmask = 0x1, addr[0] = 0;
- block 0 row 0 gives wdata = 0x00.
REQ-041 Install idx 40, value 0, mask 0xFFFFFFF: every write has addr[0] = 1, wmask = 0x2 and wdata = 0x0000_0100.
REQ-042 Install idx 0 and idx 3 with the same value, then invalidate idx 0: the matching row byte goes 0x09 -> 0x08; out_done pulses once per request.
REQ-043 Hold valid during WRITE with a new request: it is accepted only in IDLE, exactly once, with its 512 writes following.
REQ-044 Assert in_rstb low at write 200: outputs go idle immediately; after release the INIT sequence restarts.
